// File: rtl/game2048_move_ctrl_if.sv
// rtl/game2048_move_ctrl_if.sv - button/move signal bundle between board inputs, move controller and game2048
// Ports (signals):
//   btn        [3:0] raw push buttons, active-high (3 right, 2 left, 1 down, 0 up)
//   game_state [1:0] 2'b00 playing, anything else game over
//   direction  [3:0] one-hot move pulse, same mapping as btn
//   busy             controller not idle
// Modports: master drives btn/game_state, slave (the controller) drives direction/busy.
interface game2048_move_ctrl_if;
    logic [3:0] btn;
    logic [1:0] game_state;
    logic [3:0] direction;
    logic       busy;

    modport master (
        output btn,
        output game_state,
        input  direction,
        input  busy
    );

    modport slave (
        input  btn,
        input  game_state,
        output direction,
        output busy
    );
endinterface

// File: rtl/game2048_move_ctrl.sv
// rtl/game2048_move_ctrl.sv - debounced single-pulse move command generator for game2048
// Ports:
//   clk  system clock, all state on rising edge
//   rst  asynchronous active-low reset
//   bus  game2048_move_ctrl_if.slave: btn, game_state in; direction, busy out
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized cycles required before a move fires (1..65535)
//   GAP_CYCLES       idle cycles enforced after release before a new press is seen (1..65535)
module game2048_move_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned GAP_CYCLES      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    game2048_move_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        FIRE,
        WAIT_RELEASE,
        GAP
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    logic [3:0]  sync1;
    logic [3:0]  sbtn;
    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [15:0] count_inc;
    logic [3:0]  cand;
    logic [3:0]  cand_next;
    logic [3:0]  direction_q;
    logic        busy_q;
    logic        one_hot;
    logic        multi;
    logic        playing;

    // Two-flop synchronizer; nothing downstream looks at raw btn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 4'b0000;
            sbtn  <= 4'b0000;
        end else begin
            sync1 <= bus.btn;
            sbtn  <= sync1;
        end
    end

    // x & (x-1) clears the lowest set bit, so zero result means at most one bit set.
    assign one_hot   = (sbtn != 4'b0000) && ((sbtn & (sbtn - 4'd1)) == 4'b0000);
    assign multi     = (sbtn != 4'b0000) && !one_hot;
    assign playing   = (bus.game_state == 2'b00);
    assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

    always_comb begin
        state_next = state;
        count_next = count;
        cand_next  = cand;
        unique case (state)
            IDLE: begin
                if (one_hot && playing) begin
                    cand_next  = sbtn;
                    count_next = 16'd0;
                    state_next = DEBOUNCE;
                end else if (multi) begin
                    state_next = WAIT_RELEASE;
                end
            end
            DEBOUNCE: begin
                // Game over wins over everything: never let a pending press fire.
                if (!playing) begin
                    state_next = WAIT_RELEASE;
                end else if (sbtn != cand) begin
                    state_next = (sbtn == 4'b0000) ? IDLE : WAIT_RELEASE;
                end else if (count == DEB_LAST) begin
                    state_next = FIRE;
                end else begin
                    count_next = count_inc;
                end
            end
            FIRE: begin
                state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (sbtn == 4'b0000) begin
                    count_next = 16'd0;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (count == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= 16'd0;
            cand        <= 4'b0000;
            direction_q <= 4'b0000;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            cand        <= cand_next;
            direction_q <= (state_next == FIRE) ? cand_next : 4'b0000;
            busy_q      <= (state_next != IDLE);
        end
    end

    assign bus.direction = direction_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_game2048_move_ctrl.sv
// tb/tb_game2048_move_ctrl.sv - self-checking bench for game2048_move_ctrl
module tb_game2048_move_ctrl;

    localparam int DEB = 4;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    game2048_move_ctrl_if bus();

    game2048_move_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: input delay line plus a handful of "why are we not ready" flags.
    logic [3:0] m_d1, m_d2, m_val, m_dir;
    logic       m_busy;
    bit         m_locked, m_fire;
    int         m_cool, m_run;

    always @(posedge clk or negedge rst) begin
        logic [3:0] s;
        logic [1:0] g;
        if (!rst) begin
            m_d1 = 0; m_d2 = 0; m_val = 0;
            m_locked = 0; m_fire = 0; m_cool = 0; m_run = 0;
        end else begin
            s = m_d2;
            g = bus.game_state;
            m_d2 = m_d1;
            m_d1 = bus.btn;
            if (m_fire) begin
                m_fire = 0;
                m_locked = 1;
            end else if (m_locked) begin
                if (s == 0) begin
                    m_locked = 0;
                    m_cool = GAP;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (m_run > 0) begin
                if (g != 0) begin
                    m_run = 0;
                    m_locked = 1;
                end else if (s != m_val) begin
                    m_run = 0;
                    m_locked = (s != 0);
                end else if (m_run == DEB) begin
                    m_run = 0;
                    m_fire = 1;
                end else begin
                    m_run++;
                end
            end else begin
                if ($countones(s) == 1 && g == 0) begin
                    m_run = 1;
                    m_val = s;
                end else if ($countones(s) >= 2) begin
                    m_locked = 1;
                end
            end
        end
        m_dir  = m_fire ? m_val : 4'b0000;
        m_busy = m_locked || m_fire || (m_cool > 0) || (m_run > 0);
    end

    // Every-cycle compare plus pulse log.
    int         pulse_count = 0;
    int         pulse_cyc [4];
    logic [3:0] pulse_val [4];

    always @(negedge clk) begin
        check("cyc_direction", {28'd0, bus.direction}, {28'd0, m_dir});
        check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
        if (bus.direction != 4'b0000) begin
            if (pulse_count < 4) begin
                pulse_cyc[pulse_count] = cyc;
                pulse_val[pulse_count] = bus.direction;
            end
            pulse_count++;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int press_cyc;
        int base;
        bit seen;
        bus.btn = 4'b0000;
        bus.game_state = 2'b00;
        idle_cycles(3);
        check("reset_direction", {28'd0, bus.direction}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        idle_cycles(4);
        check("post_reset_busy", {31'd0, bus.busy}, 32'd0);

        // Long hold: one pulse, fixed latency, no repeat.
        pulse_count = 0;
        press_cyc = cyc;
        bus.btn = 4'b1000;
        idle_cycles(20);
        bus.btn = 4'b0000;
        idle_cycles(10);
        check("hold_pulses", pulse_count, 1);
        check("hold_value", {28'd0, pulse_val[0]}, 32'h8);
        check("hold_latency", pulse_cyc[0] - press_cyc, 7);
        check("hold_busy_end", {31'd0, bus.busy}, 32'd0);

        // Short glitch: no pulse, back to idle.
        pulse_count = 0;
        bus.btn = 4'b0100;
        idle_cycles(2);
        bus.btn = 4'b0000;
        idle_cycles(8);
        check("glitch_pulses", pulse_count, 0);
        check("glitch_busy", {31'd0, bus.busy}, 32'd0);

        // Two buttons: locked until release plus gap.
        pulse_count = 0;
        bus.btn = 4'b0011;
        idle_cycles(10);
        check("multi_busy_held", {31'd0, bus.busy}, 32'd1);
        bus.btn = 4'b0000;
        idle_cycles(8);
        check("multi_pulses", pulse_count, 0);
        check("multi_busy_end", {31'd0, bus.busy}, 32'd0);

        // Press, release, press another during the gap.
        pulse_count = 0;
        bus.btn = 4'b0001;
        idle_cycles(8);
        bus.btn = 4'b0000;
        idle_cycles(3);
        bus.btn = 4'b0010;
        idle_cycles(20);
        bus.btn = 4'b0000;
        idle_cycles(10);
        check("gap_pulses", pulse_count, 2);
        check("gap_first", {28'd0, pulse_val[0]}, 32'h1);
        check("gap_second", {28'd0, pulse_val[1]}, 32'h2);
        check("gap_spacing_min", {31'd0, (pulse_cyc[1] - pulse_cyc[0]) >= (DEB + GAP + 3)}, 32'd1);

        // Game over while idle: press ignored entirely.
        pulse_count = 0;
        bus.game_state = 2'b01;
        bus.btn = 4'b1000;
        idle_cycles(10);
        check("over_idle_busy", {31'd0, bus.busy}, 32'd0);
        bus.btn = 4'b0000;
        idle_cycles(4);
        bus.game_state = 2'b00;
        idle_cycles(2);
        bus.btn = 4'b1000;
        idle_cycles(10);
        bus.btn = 4'b0000;
        idle_cycles(10);
        check("over_then_play_pulses", pulse_count, 1);

        // Game over arriving mid-debounce: aborted, waits for release.
        pulse_count = 0;
        bus.btn = 4'b0100;
        idle_cycles(4);
        bus.game_state = 2'b10;
        idle_cycles(10);
        check("over_debounce_busy", {31'd0, bus.busy}, 32'd1);
        bus.btn = 4'b0000;
        bus.game_state = 2'b00;
        idle_cycles(10);
        check("over_debounce_pulses", pulse_count, 0);

        // Reset during the FIRE cycle.
        bus.btn = 4'b0001;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.direction != 4'b0000) seen = 1;
        end
        check("fire_seen", {31'd0, seen}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("reset_fire_direction", {28'd0, bus.direction}, 32'd0);
        check("reset_fire_busy", {31'd0, bus.busy}, 32'd0);
        bus.btn = 4'b0000;
        base = pulse_count;
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(10);
        check("reset_fire_no_pulse", pulse_count - base, 0);
        check("reset_fire_busy_end", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game2048_move_ctrl.md
GAME2048_MOVE_CTRL -- requirements
Module: game2048_move_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive sampled cycles a single-button pattern must hold stable before a move is issued (legal range 1..65535).
REQ-002 Parameter GAP_CYCLES, default 8: minimum idle cycles after a move pulse before another pulse may be issued (legal range 1..65535).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn  input  4  raw, asynchronous push buttons, active-high; bit3 right, bit2 left, bit1 down, bit0 up.
REQ-006 game_state  input  2  game2048 status; 2'b00 = playing, any other value = game over (won/lost).
REQ-007 direction  output  4  one-hot move command to game2048, same bit mapping as btn; 4'b0000 = no move.
REQ-008 busy  output  1  high whenever the controller is not in IDLE.

Function
REQ-009 btn SHALL pass through a 2-flop synchronizer per bit; all further logic SHALL use only the synchronized value sbtn (2-cycle input latency).
REQ-010 FSM states SHALL be IDLE, DEBOUNCE, FIRE, WAIT_RELEASE and GAP.
REQ-011 IDLE: if sbtn is exactly one-hot and game_state==2'b00 -> latch sbtn into cand, clear counter, go DEBOUNCE; if sbtn has 2+ bits set -> WAIT_RELEASE; otherwise stay.
REQ-012 DEBOUNCE: counter SHALL increment each cycle sbtn==cand; when counter reaches DEBOUNCE_CYCLES-1 with sbtn==cand -> FIRE.
REQ-013 DEBOUNCE: if sbtn!=cand -> go IDLE if sbtn==0, else WAIT_RELEASE; no pulse issued.
REQ-014 DEBOUNCE: if game_state!=2'b00 in any cycle -> WAIT_RELEASE; no pulse issued.
REQ-015 FIRE SHALL last exactly one cycle, drive direction=cand, then go WAIT_RELEASE.
REQ-016 direction SHALL be registered, one-hot, and non-zero only during the single FIRE cycle; it SHALL be 4'b0000 in every other state.
REQ-017 WAIT_RELEASE: stay until sbtn==4'b0000 for one cycle, then clear counter and go GAP; holding a button SHALL never auto-repeat.
REQ-018 GAP: counter SHALL increment each cycle; at GAP_CYCLES-1 -> IDLE; buttons pressed during GAP SHALL be ignored and, if still held on IDLE entry, evaluated per REQ-011 with a fresh debounce.
REQ-019 Counter SHALL be 16 bits, saturate at all-ones, never wrap.
REQ-020 Minimum spacing between two direction pulses SHALL be DEBOUNCE_CYCLES + GAP_CYCLES + 3 cycles (FIRE, release detection and re-synchronization included).
REQ-021 game_state!=2'b00 SHALL never produce a pulse; a pulse already in FIRE SHALL complete.
REQ-022 busy SHALL be a registered decode of state, valid the same cycle as the state.

Reset
REQ-023 While rst==0, direction=4'b0000, busy=0, state=IDLE, counter=0, cand=0, and synchronizer flops=0, all applied asynchronously.
REQ-024 Reset assertion mid-operation (including during FIRE) SHALL force direction to 0 immediately, with no pulse completion.
REQ-025 Reset deassertion SHALL be synchronized externally; the first state change SHALL come no earlier than the second clk edge after release.

Verification
REQ-026 DEBOUNCE_CYCLES=4, GAP_CYCLES=2; hold btn=4'b1000 for 20 cycles -> exactly one direction=4'b1000 pulse, 1 cycle wide, 2+4 cycles after press (±1 edge); no repeat while held.
REQ-027 btn=4'b0100 glitch of 2 cycles, then 0 -> direction stays 0; FSM returns to IDLE; busy falls.
REQ-028 btn=4'b0011 held 10 cycles, then 0 -> no pulse; busy high until release, plus GAP.
REQ-029 Press 4'b0001, release, then press 4'b0010 during GAP and hold -> first pulse 4'b0001; second pulse 4'b0010 no earlier than REQ-020 spacing.
REQ-030 game_state=2'b01 with btn=4'b1000 held -> no pulse; after game_state returns to 2'b00, release and re-press -> one pulse.
REQ-031 Assert rst=0 in the FIRE cycle -> direction is 0 before the next clk edge; after release with btn=0, busy=0 and no pulse.
